// File: rtl/noc_vc_inject.sv
// noc_vc_inject: local-port injection adapter between client logic and a
// router's local input port. One FIFO per virtual channel buffers client
// flits; a round-robin arbiter picks among VCs that hold data and whose
// router-side ready is high, and one registered flit per cycle is launched.
//
// Ports:
//   clk, rst_            rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_vch   client flit, valid and target VC
//   in_rdy[N_VC]         per-VC "FIFO not full" (registered)
//   odata/ovalid/ovch    registered flit, valid and VC to the router
//   ordy[N_VC]           router per-VC ready, used only for arbitration
//   sent_cnt             saturating count of launched flits
//   err_vch              sticky flag: a flit targeted a VC >= N_VC
//   lock_o               (NOC_PKT_LOCK_EN only) arbiter locked to a packet
//
// Optional feature macro: NOC_PKT_LOCK_EN -- packet-level locking of the
// arbiter from head launch (type 01) until tail launch (type 10).
module noc_vc_inject #(
  parameter int unsigned DATA_W = 35,
  parameter int unsigned N_VC   = 2,
  parameter int unsigned VCW    = 1,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic [VCW-1:0]    in_vch,
  output logic [N_VC-1:0]   in_rdy,
  output logic [DATA_W-1:0] odata,
  output logic              ovalid,
  output logic [VCW-1:0]    ovch,
  input  logic [N_VC-1:0]   ordy,
  output logic [15:0]       sent_cnt,
`ifdef NOC_PKT_LOCK_EN
  output logic              lock_o,
`endif
  output logic              err_vch
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem     [N_VC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr  [N_VC];
  logic [PTR_W-1:0]  rd_ptr  [N_VC];
  logic [CNT_W-1:0]  cnt     [N_VC];
  logic [CNT_W-1:0]  cnt_nxt [N_VC];
  logic [VCW-1:0]    rr_ptr;
  logic [N_VC-1:0]   push;
  logic [N_VC-1:0]   pop;
  logic [N_VC-1:0]   elig;
  logic              bad_vch;
  logic              win_found;
  logic [VCW-1:0]    win_idx;
  logic [DATA_W-1:0] win_data;
`ifdef NOC_PKT_LOCK_EN
  logic [VCW-1:0]    lock_vc;
  logic [1:0]        win_type;
`endif

  // Push decode: out-of-range VCs are dropped and flagged.
  always_comb begin
    push    = '0;
    bad_vch = 1'b0;
    if (in_valid) begin
      if (32'(in_vch) >= N_VC) begin
        bad_vch = 1'b1;
      end else begin
        for (int v = 0; v < N_VC; v++) begin
          if (in_vch == VCW'(v)) push[v] = in_rdy[v];
        end
      end
    end
  end

  // Eligibility and round-robin search starting just after rr_ptr.
  always_comb begin
    elig      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int v = 0; v < N_VC; v++) begin
      elig[v] = (cnt[v] != '0) && ordy[v];
`ifdef NOC_PKT_LOCK_EN
      if (lock_o && (lock_vc != VCW'(v))) elig[v] = 1'b0;
`endif
    end
    for (int i = 1; i <= N_VC; i++) begin
      for (int v = 0; v < N_VC; v++) begin
        if (!win_found && elig[v] &&
            (((32'(rr_ptr) + 32'(i)) % N_VC) == 32'(v))) begin
          win_found = 1'b1;
          win_idx   = VCW'(v);
        end
      end
    end
  end

  // Pop select, head-of-winner mux and next occupancy.
  always_comb begin
    pop      = '0;
    win_data = '0;
    for (int v = 0; v < N_VC; v++) begin
      if (win_found && (win_idx == VCW'(v))) begin
        pop[v]   = 1'b1;
        win_data = mem[v][rd_ptr[v]];
      end
      cnt_nxt[v] = cnt[v];
      if (push[v] && !pop[v]) begin
        cnt_nxt[v] = cnt[v] + CNT_W'(1);
      end else if (!push[v] && pop[v]) begin
        cnt_nxt[v] = cnt[v] - CNT_W'(1);
      end
    end
  end

`ifdef NOC_PKT_LOCK_EN
  assign win_type = win_data[DATA_W-1 -: 2];
`endif

  // FIFO storage; no reset needed since pointers define validity.
  always_ff @(posedge clk) begin
    for (int v = 0; v < N_VC; v++) begin
      if (push[v] && !rst_) mem[v][wr_ptr[v]] <= in_data;
    end
  end

  // FIFO pointers, ready flags, launch register and counters.
  always_ff @(posedge clk) begin
    if (rst_) begin
      for (int v = 0; v < N_VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v]    <= '0;
      end
      in_rdy   <= '1;
      rr_ptr   <= VCW'(N_VC - 1);
      odata    <= '0;
      ovalid   <= 1'b0;
      ovch     <= '0;
      sent_cnt <= '0;
      err_vch  <= 1'b0;
    end else begin
      for (int v = 0; v < N_VC; v++) begin
        if (push[v]) wr_ptr[v] <= (wr_ptr[v] == PTR_LAST) ? '0 : wr_ptr[v] + PTR_W'(1);
        if (pop[v])  rd_ptr[v] <= (rd_ptr[v] == PTR_LAST) ? '0 : rd_ptr[v] + PTR_W'(1);
        cnt[v]    <= cnt_nxt[v];
        in_rdy[v] <= (cnt_nxt[v] != CNT_FULL);
      end
      ovalid <= win_found;
      if (win_found) begin
        odata  <= win_data;
        ovch   <= win_idx;
        rr_ptr <= win_idx;
        if (sent_cnt != 16'hFFFF) sent_cnt <= sent_cnt + 16'd1;
      end
      if (bad_vch) err_vch <= 1'b1;
    end
  end

`ifdef NOC_PKT_LOCK_EN
  // Packet lock: set by a head launch, released by that VC's tail launch.
  always_ff @(posedge clk) begin
    if (rst_) begin
      lock_o  <= 1'b0;
      lock_vc <= '0;
    end else if (win_found) begin
      if (!lock_o && (win_type == 2'b01)) begin
        lock_o  <= 1'b1;
        lock_vc <= win_idx;
      end else if (lock_o && (win_type == 2'b10)) begin
        lock_o  <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_vc_inject.sv
// tb_noc_vc_inject: randomized bench for noc_vc_inject with a queue-based
// reference model. The driver applies stimulus on the falling edge and
// predicts the next rising edge; predicted launches go into a scoreboard
// that a separate monitor drains whenever the DUT shows ovalid.
module tb_noc_vc_inject;

  localparam int unsigned DATA_W = 35;
  localparam int unsigned N_VC   = 2;
  localparam int unsigned VCW    = 2;
  localparam int unsigned DEPTH  = 4;

  logic              clk      = 1'b0;
  logic              rst_     = 1'b1;
  logic [DATA_W-1:0] in_data  = '0;
  logic              in_valid = 1'b0;
  logic [VCW-1:0]    in_vch   = '0;
  logic [N_VC-1:0]   ordy     = '0;
  logic [N_VC-1:0]   in_rdy;
  logic [DATA_W-1:0] odata;
  logic              ovalid;
  logic [VCW-1:0]    ovch;
  logic [15:0]       sent_cnt;
  logic              err_vch;
`ifdef NOC_PKT_LOCK_EN
  logic              lock_o;
`endif

  always #5 clk = ~clk;

  noc_vc_inject #(
    .DATA_W (DATA_W),
    .N_VC   (N_VC),
    .VCW    (VCW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_     (rst_),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_vch   (in_vch),
    .in_rdy   (in_rdy),
    .odata    (odata),
    .ovalid   (ovalid),
    .ovch     (ovch),
    .ordy     (ordy),
    .sent_cnt (sent_cnt),
`ifdef NOC_PKT_LOCK_EN
    .lock_o   (lock_o),
`endif
    .err_vch  (err_vch)
  );

  // Reference model state: per-VC flit queues plus the arbiter's last winner.
  logic [DATA_W-1:0] mq [N_VC][$];
  int                m_ptr     = N_VC - 1;
  logic              m_locked  = 1'b0;
  int                m_lock_vc = 0;

  // Scoreboard and per-cycle expectations.
  logic [DATA_W-1:0] exp_d [$];
  int                exp_c [$];
  logic              exp_valid = 1'b0;
  logic [N_VC-1:0]   exp_rdy   = '1;
  int                exp_sent  = 0;
  logic              exp_err   = 1'b0;
  logic              exp_zero  = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] typed(input logic [1:0] t);
    logic [DATA_W-1:0] d;
    d = rnd_data();
    d[DATA_W-1 -: 2] = t;
    return d;
  endfunction

  // Apply one cycle of stimulus and advance the model to the next edge.
  task automatic step(input logic rst, input logic v, input logic [VCW-1:0] vch,
                      input logic [DATA_W-1:0] d, input logic [N_VC-1:0] r);
    int win;
    int vi;
    logic [DATA_W-1:0] f;
    @(negedge clk);
    rst_     = rst;
    in_valid = v;
    in_vch   = vch;
    in_data  = d;
    ordy     = r;
    if (rst) begin
      for (int k = 0; k < N_VC; k++) mq[k].delete();
      exp_d.delete();
      exp_c.delete();
      m_ptr     = N_VC - 1;
      m_locked  = 1'b0;
      exp_valid = 1'b0;
      exp_rdy   = '1;
      exp_sent  = 0;
      exp_err   = 1'b0;
      exp_zero  = 1'b1;
    end else begin
      exp_zero = 1'b0;
      vi  = int'(vch);
      win = -1;
      for (int i = 1; i <= N_VC; i++) begin
        int c;
        c = (m_ptr + i) % N_VC;
        if (win < 0 && mq[c].size() > 0 && r[c] && (!m_locked || c == m_lock_vc)) win = c;
      end
      // Acceptance uses the occupancy seen before this edge's pop.
      if (v && vi >= N_VC) exp_err = 1'b1;
      if (win >= 0) begin
        f = mq[win].pop_front();
        exp_d.push_back(f);
        exp_c.push_back(win);
        m_ptr = win;
        if (exp_sent < 65535) exp_sent++;
        if (!m_locked && f[DATA_W-1 -: 2] == 2'b01) begin
          m_locked  = 1'b1;
          m_lock_vc = win;
        end else if (m_locked && f[DATA_W-1 -: 2] == 2'b10) begin
          m_locked = 1'b0;
        end
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      if (v && vi < N_VC && (mq[vi].size() + ((win == vi) ? 1 : 0)) < DEPTH)
        mq[vi].push_back(d);
      for (int k = 0; k < N_VC; k++) exp_rdy[k] = (mq[k].size() != DEPTH);
    end
`ifndef NOC_PKT_LOCK_EN
    m_locked = 1'b0;
`endif
  endtask

  task automatic idle(input int n, input logic [N_VC-1:0] r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, r);
  endtask

  // Monitor: compare registered outputs 1 time unit after each rising edge.
  initial begin
    logic [DATA_W-1:0] d;
    int c;
    forever begin
      @(posedge clk);
      #1;
      check("ovalid", 64'(ovalid), 64'(exp_valid));
      if (ovalid) begin
        if (exp_d.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL launch: got unexpected flit %0h on vc %0d, expected none at %0t",
                   odata, ovch, $time);
        end else begin
          d = exp_d.pop_front();
          c = exp_c.pop_front();
          check("odata", 64'(odata), 64'(d));
          check("ovch", 64'(ovch), 64'(c));
        end
      end
      check("in_rdy", 64'(in_rdy), 64'(exp_rdy));
      check("sent_cnt", 64'(sent_cnt), 64'(exp_sent));
      check("err_vch", 64'(err_vch), 64'(exp_err));
      if (exp_zero) begin
        check("odata_reset", 64'(odata), 64'd0);
        check("ovch_reset", 64'(ovch), 64'd0);
      end
`ifdef NOC_PKT_LOCK_EN
      check("lock_o", 64'(lock_o), 64'(m_locked));
`endif
    end
  end

  initial begin
    logic          rr;
    logic          vv;
    logic [VCW-1:0] vc;
    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0);

    // Four flits on VC0 streaming straight through.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd0, typed(2'b11), 2'b11);
    idle(4, 2'b11);

    // Fill VC1 with the router stalled, try a fifth push, then drain.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'd1, typed(2'b11), 2'b00);
    idle(2, 2'b00);
    idle(6, 2'b10);

    // Preload both VCs and release: launches alternate VC0, VC1.
    step(1'b0, 1'b1, 2'd0, typed(2'b11), 2'b00);
    step(1'b0, 1'b1, 2'd0, typed(2'b11), 2'b00);
    step(1'b0, 1'b1, 2'd1, typed(2'b11), 2'b00);
    step(1'b0, 1'b1, 2'd1, typed(2'b11), 2'b00);
    idle(6, 2'b11);

    // Out-of-range VC, then push concurrent with pop on a busy FIFO.
    step(1'b0, 1'b1, 2'd3, typed(2'b11), 2'b00);
    step(1'b0, 1'b1, 2'd2, typed(2'b11), 2'b00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd0, typed(2'b11), 2'b00);
    step(1'b0, 1'b1, 2'd0, typed(2'b11), 2'b01);
    step(1'b0, 1'b1, 2'd0, typed(2'b11), 2'b00);
    idle(7, 2'b11);

    // Reset with flits buffered on both VCs; nothing stale may come out.
    step(1'b0, 1'b1, 2'd0, typed(2'b00), 2'b00);
    step(1'b0, 1'b1, 2'd1, typed(2'b00), 2'b00);
    step(1'b0, 1'b1, 2'd0, typed(2'b00), 2'b00);
    step(1'b1, 1'b0, '0, '0, 2'b00);
    idle(5, 2'b11);

    // Packet on VC0 (head/body/tail) against a single-flit packet on VC1.
    step(1'b0, 1'b1, 2'd0, typed(2'b01), 2'b00);
    step(1'b0, 1'b1, 2'd0, typed(2'b00), 2'b00);
    step(1'b0, 1'b1, 2'd1, typed(2'b11), 2'b00);
    step(1'b0, 1'b1, 2'd0, typed(2'b10), 2'b00);
    idle(6, 2'b11);

    // Randomized traffic with occasional bad VCs and resets.
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 299) == 0);
      vv = ($urandom_range(0, 3) != 0);
      vc = ($urandom_range(0, 19) == 0) ? 2'd3 : VCW'($urandom_range(0, N_VC - 1));
      step(rr, vv, vc, rnd_data(), N_VC'($urandom()));
    end
    idle(20, 2'b11);

    @(negedge clk);
    check("scoreboard_empty", 64'(exp_d.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
